riscv_mem_arbiter: RTL and testbench

Shares one single-port block-RAM port between the core's instruction-fetch requester and its data (load/store) requester. Each side uses a valid/ready request handshake and gets a fixed-latency response. Requests are pipelined at one accept per cycle. Data has fixed priority, with a starvation guard that forces a fetch grant. The block sits between riscv_core and the unified instruction/data BRAM.

---
 rtl/riscv_types.sv | 27 ++
 rtl/riscv_mem_arbiter_if.sv | 54 +++++
 rtl/riscv_mem_tag_pipe.sv | 39 +++
 rtl/riscv_mem_arbiter.sv | 107 ++++++++++
 tb/tb_riscv_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_types.sv
// ============================================================================
//  Module      : riscv_types
//  Description : Shared types for the memory arbiter (requester port id and
//                the per-request tag carried alongside the BRAM latency).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_types;

    // Byte-address bits below the 32-bit word index
    localparam int c_WORD_LSB = 2;

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_DATA = 1'b1
    } MemPort;

    typedef struct packed {
        logic   valid;
        MemPort port;
        logic   is_write;
    } MemTag;

endpackage

`default_nettype wire

// File: rtl/riscv_mem_arbiter_if.sv
// ============================================================================
//  Module      : riscv_mem_arbiter_if
//  Description : Fetch/data requester handshakes plus the BRAM port, bundled
//                for the arbiter (slave) and its environment (master).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface riscv_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32
) ();

    logic                  imem_req_valid_in;
    logic                  imem_req_ready_out;
    logic [ADDR_WIDTH-1:0] imem_addr_in;
    logic                  imem_resp_valid_out;
    logic [31:0]           imem_resp_data_out;

    logic                  dmem_req_valid_in;
    logic                  dmem_req_ready_out;
    logic [ADDR_WIDTH-1:0] dmem_addr_in;
    logic                  dmem_we_in;
    logic [3:0]            dmem_wstrb_in;
    logic [31:0]           dmem_wdata_in;
    logic                  dmem_resp_valid_out;
    logic [31:0]           dmem_resp_data_out;

    logic                  mem_en_out;
    logic [ADDR_WIDTH-3:0] mem_addr_out;
    logic [3:0]            mem_we_out;
    logic [31:0]           mem_wdata_out;
    logic [31:0]           mem_rdata_in;

    modport slave (
        input  imem_req_valid_in, imem_addr_in,
        input  dmem_req_valid_in, dmem_addr_in, dmem_we_in, dmem_wstrb_in, dmem_wdata_in,
        input  mem_rdata_in,
        output imem_req_ready_out, imem_resp_valid_out, imem_resp_data_out,
        output dmem_req_ready_out, dmem_resp_valid_out, dmem_resp_data_out,
        output mem_en_out, mem_addr_out, mem_we_out, mem_wdata_out
    );

    modport master (
        output imem_req_valid_in, imem_addr_in,
        output dmem_req_valid_in, dmem_addr_in, dmem_we_in, dmem_wstrb_in, dmem_wdata_in,
        output mem_rdata_in,
        input  imem_req_ready_out, imem_resp_valid_out, imem_resp_data_out,
        input  dmem_req_ready_out, dmem_resp_valid_out, dmem_resp_data_out,
        input  mem_en_out, mem_addr_out, mem_we_out, mem_wdata_out
    );

endinterface

`default_nettype wire

// File: rtl/riscv_mem_tag_pipe.sv
// ============================================================================
//  Module      : riscv_mem_tag_pipe
//  Description : DEPTH-stage delay line of request tags, aligned with the
//                BRAM read latency; synchronous clear drops in-flight tags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_mem_tag_pipe
    import riscv_types::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic  clk_in,
    input  wire logic  rst_in,
    input  wire MemTag tag_in,
    output MemTag      tag_out
);

    MemTag r_stage [DEPTH];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign tag_out = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/riscv_mem_arbiter.sv
// ============================================================================
//  Module      : riscv_mem_arbiter
//  Description : Shares one BRAM port between instruction fetch and data
//                accesses; data wins ties unless fetch has been starved.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_mem_arbiter
    import riscv_types::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic          clk_in,
    input  wire logic          rst_in,
    riscv_mem_arbiter_if.slave bus
);

    localparam int                 c_CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_LIMIT);

    logic [c_CNT_W-1:0] r_starve_cnt;
    logic               w_fetch_forced;
    logic               w_grant_data;
    logic               w_grant_inst;
    MemTag              w_tag_in;
    MemTag              w_tag_out;
    logic               w_unused_addr_bits;

    // Reset gates the grants so every output is quiet while rst_in is high
    always_comb begin
        w_fetch_forced = bus.imem_req_valid_in && (r_starve_cnt == c_STARVE_MAX);
        w_grant_data   = !rst_in && bus.dmem_req_valid_in && !w_fetch_forced;
        w_grant_inst   = !rst_in && bus.imem_req_valid_in && !w_grant_data;
    end

    assign bus.imem_req_ready_out = w_grant_inst;
    assign bus.dmem_req_ready_out = w_grant_data;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_starve_cnt <= '0;
        end else if (!bus.imem_req_valid_in || w_grant_inst) begin
            r_starve_cnt <= '0;
        end else if (w_grant_data && (r_starve_cnt != c_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Write data is a don't-care on fetch grants, so it simply follows dmem
    always_comb begin
        bus.mem_en_out    = 1'b0;
        bus.mem_addr_out  = '0;
        bus.mem_we_out    = 4'b0000;
        bus.mem_wdata_out = 32'h0;
        if (w_grant_data) begin
            bus.mem_en_out    = 1'b1;
            bus.mem_addr_out  = bus.dmem_addr_in[ADDR_WIDTH-1:c_WORD_LSB];
            bus.mem_we_out    = bus.dmem_we_in ? bus.dmem_wstrb_in : 4'b0000;
            bus.mem_wdata_out = bus.dmem_wdata_in;
        end else if (w_grant_inst) begin
            bus.mem_en_out    = 1'b1;
            bus.mem_addr_out  = bus.imem_addr_in[ADDR_WIDTH-1:c_WORD_LSB];
            bus.mem_wdata_out = bus.dmem_wdata_in;
        end
    end

    assign w_unused_addr_bits = ^{bus.imem_addr_in[c_WORD_LSB-1:0],
                                  bus.dmem_addr_in[c_WORD_LSB-1:0]};

    always_comb begin
        w_tag_in.valid    = w_grant_inst || w_grant_data;
        w_tag_in.port     = w_grant_data ? PORT_DATA : PORT_INST;
        w_tag_in.is_write = w_grant_data && bus.dmem_we_in;
    end

    riscv_mem_tag_pipe #(
        .DEPTH   (MEM_LATENCY)
    ) u_tag_pipe (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .tag_in  (w_tag_in),
        .tag_out (w_tag_out)
    );

    // Read data is a passthrough; store acknowledges return zero
    always_comb begin
        bus.imem_resp_valid_out = 1'b0;
        bus.imem_resp_data_out  = 32'h0;
        bus.dmem_resp_valid_out = 1'b0;
        bus.dmem_resp_data_out  = 32'h0;
        if (!rst_in && w_tag_out.valid) begin
            if (w_tag_out.port == PORT_DATA) begin
                bus.dmem_resp_valid_out = 1'b1;
                bus.dmem_resp_data_out  = w_tag_out.is_write ? 32'h0 : bus.mem_rdata_in;
            end else begin
                bus.imem_resp_valid_out = 1'b1;
                bus.imem_resp_data_out  = bus.mem_rdata_in;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
// ============================================================================
//  Module      : tb_riscv_mem_arbiter
//  Description : Self-checking bench: directed vector table, random traffic
//                against a queue-based reference model, latency-1 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_mem_arbiter;

    localparam int LAT   = 2;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;

    always #5 clk = ~clk;

    riscv_mem_arbiter_if #(.ADDR_WIDTH(32)) bus  ();
    riscv_mem_arbiter_if #(.ADDR_WIDTH(32)) bus2 ();

    riscv_mem_arbiter #(.ADDR_WIDTH(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)) u_dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    riscv_mem_arbiter #(.ADDR_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(LIMIT)) u_dut_l1 (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus2)
    );

    // Write-first BRAM with a 2-cycle read pipe behind the main instance
    logic [31:0] bram [128];
    logic [31:0] bram_wr_word;
    logic [31:0] bram_rd [2];

    always_comb begin
        bram_wr_word = bram[bus.mem_addr_out[6:0]];
        for (int b = 0; b < 4; b++) begin
            if (bus.mem_we_out[b]) bram_wr_word[8*b +: 8] = bus.mem_wdata_out[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) bram[i] <= (i == 8) ? 32'h0 : 32'(32'h1000 + i);
        end else if (bus.mem_en_out) begin
            bram[bus.mem_addr_out[6:0]] <= bram_wr_word;
            bram_rd[0] <= bram_wr_word;
        end
        bram_rd[1] <= bram_rd[0];
    end
    assign bus.mem_rdata_in = bram_rd[1];

    // Read-only 1-cycle BRAM behind the latency-1 instance: word i holds 0x1000+i
    logic [31:0] bram2_rd;
    always @(posedge clk) begin
        if (bus2.mem_en_out) bram2_rd <= 32'h1000 + {25'd0, bus2.mem_addr_out[6:0]};
    end
    assign bus2.mem_rdata_in = bram2_rd;

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        bit          is_data;
        logic [31:0] data;
    } resp_t;

    resp_t       rq[$];
    logic [31:0] shadow [128];
    int          starve_m;
    int          cyc;
    int          n_pass;
    int          n_total;
    bit          acc_i, acc_d;
    bit          g_gi, g_gd, g_iv, g_we;
    logic [29:0] g_ea;
    logic [3:0]  g_strb;
    logic [31:0] g_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic sample_check();
        bit          rv_i, rv_d;
        logic [31:0] rd_i, rd_d;
        logic [3:0]  ewe;
        #2;
        g_iv = bus.imem_req_valid_in;
        g_gi = 0; g_gd = 0; g_ea = '0; ewe = '0;
        rv_i = 0; rv_d = 0; rd_i = '0; rd_d = '0;
        if (!rst) begin
            if (bus.dmem_req_valid_in && !(g_iv && starve_m >= LIMIT)) g_gd = 1;
            else if (g_iv) g_gi = 1;
            if (g_gd) g_ea = 30'(bus.dmem_addr_in / 4);
            else if (g_gi) g_ea = 30'(bus.imem_addr_in / 4);
            if (g_gd && bus.dmem_we_in) ewe = bus.dmem_wstrb_in;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                if (rq[0].is_data) begin rv_d = 1; rd_d = rq[0].data; end
                else begin rv_i = 1; rd_i = rq[0].data; end
            end
        end
        g_we = bus.dmem_we_in; g_strb = bus.dmem_wstrb_in; g_wdata = bus.dmem_wdata_in;
        chk("ready", {bus.imem_req_ready_out, bus.dmem_req_ready_out}, {g_gi, g_gd});
        chk("mem_ctl", {bus.mem_en_out, bus.mem_we_out, bus.mem_addr_out}, {g_gi | g_gd, ewe, g_ea});
        if (g_gd) chk("mem_wdata", bus.mem_wdata_out, g_wdata);
        else if (!g_gi) chk("mem_wdata_idle", bus.mem_wdata_out, 0);
        chk("resp_valid", {bus.imem_resp_valid_out, bus.dmem_resp_valid_out}, {rv_i, rv_d});
        chk("imem_rdata", bus.imem_resp_data_out, rd_i);
        chk("dmem_rdata", bus.dmem_resp_data_out, rd_d);
        acc_i = bus.imem_req_ready_out;
        acc_d = bus.dmem_req_ready_out;
    endtask

    task automatic advance();
        logic [31:0] w;
        resp_t       r;
        @(posedge clk);
        if (rst) begin
            rq.delete();
            starve_m = 0;
        end else begin
            if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
            w = shadow[g_ea[6:0]];
            if (g_gd && g_we) begin
                for (int b = 0; b < 4; b++) if (g_strb[b]) w[8*b +: 8] = g_wdata[8*b +: 8];
                shadow[g_ea[6:0]] = w;
                w = 32'h0;
            end
            r.due = cyc + LAT; r.is_data = g_gd; r.data = w;
            if (g_gd || g_gi) rq.push_back(r);
            if (!g_iv || g_gi) starve_m = 0;
            else if (g_gd && starve_m < LIMIT) starve_m++;
        end
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        bus.imem_req_valid_in = 0; bus.imem_addr_in = '0;
        bus.dmem_req_valid_in = 0; bus.dmem_addr_in = '0;
        bus.dmem_we_in = 0; bus.dmem_wstrb_in = '0; bus.dmem_wdata_in = '0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit iv; logic [31:0] ia; bit dv; logic [31:0] da; bit we; logic [3:0] ws; logic [31:0] wd;
        bit e_ir; bit e_dr; bit e_en; logic [29:0] e_ma; logic [3:0] e_we;
        bit e_irv; logic [31:0] e_ird; bit e_drv; logic [31:0] e_drd;
    } vec_t;

    vec_t tbl [13];

    initial begin
        n_pass = 0; n_total = 0; cyc = 0; starve_m = 0;
        for (int i = 0; i < 128; i++) shadow[i] = (i == 8) ? 32'h0 : 32'(32'h1000 + i);
        idle_inputs();
        bus2.imem_req_valid_in = 0; bus2.imem_addr_in = '0;
        bus2.dmem_req_valid_in = 0; bus2.dmem_addr_in = '0;
        bus2.dmem_we_in = 0; bus2.dmem_wstrb_in = '0; bus2.dmem_wdata_in = '0;

        tbl[0]  = '{1, 32'h0,  0, 32'h0,   0, 4'h0, 32'h0,        1, 0, 1, 30'd0,  4'h0, 0, 32'h0,    0, 32'h0};
        tbl[1]  = '{1, 32'h4,  0, 32'h0,   0, 4'h0, 32'h0,        1, 0, 1, 30'd1,  4'h0, 0, 32'h0,    0, 32'h0};
        tbl[2]  = '{1, 32'h8,  0, 32'h0,   0, 4'h0, 32'h0,        1, 0, 1, 30'd2,  4'h0, 1, 32'h1000, 0, 32'h0};
        tbl[3]  = '{0, 32'h0,  0, 32'h0,   0, 4'h0, 32'h0,        0, 0, 0, 30'd0,  4'h0, 1, 32'h1001, 0, 32'h0};
        tbl[4]  = '{0, 32'h0,  0, 32'h0,   0, 4'h0, 32'h0,        0, 0, 0, 30'd0,  4'h0, 1, 32'h1002, 0, 32'h0};
        tbl[5]  = '{1, 32'h10, 1, 32'h100, 0, 4'h0, 32'h0,        0, 1, 1, 30'd64, 4'h0, 0, 32'h0,    0, 32'h0};
        tbl[6]  = '{1, 32'h10, 0, 32'h0,   0, 4'h0, 32'h0,        1, 0, 1, 30'd4,  4'h0, 0, 32'h0,    0, 32'h0};
        tbl[7]  = '{0, 32'h0,  0, 32'h0,   0, 4'h0, 32'h0,        0, 0, 0, 30'd0,  4'h0, 0, 32'h0,    1, 32'h1040};
        tbl[8]  = '{0, 32'h0,  1, 32'h20,  1, 4'h3, 32'hDEADBEEF, 0, 1, 1, 30'd8,  4'h3, 1, 32'h1004, 0, 32'h0};
        tbl[9]  = '{0, 32'h0,  1, 32'h20,  0, 4'h0, 32'h0,        0, 1, 1, 30'd8,  4'h0, 0, 32'h0,    0, 32'h0};
        tbl[10] = '{0, 32'h0,  0, 32'h0,   0, 4'h0, 32'h0,        0, 0, 0, 30'd0,  4'h0, 0, 32'h0,    1, 32'h0};
        tbl[11] = '{0, 32'h0,  0, 32'h0,   0, 4'h0, 32'h0,        0, 0, 0, 30'd0,  4'h0, 0, 32'h0,    1, 32'h0000BEEF};
        tbl[12] = '{0, 32'h0,  0, 32'h0,   0, 4'h0, 32'h0,        0, 0, 0, 30'd0,  4'h0, 0, 32'h0,    0, 32'h0};

        @(posedge clk); #1;
        preload = 0;

        // Reset state: requests offered during reset must see all-zero outputs
        bus.imem_req_valid_in = 1; bus.imem_addr_in = 32'h4;
        bus.dmem_req_valid_in = 1; bus.dmem_addr_in = 32'h8; bus.dmem_we_in = 1; bus.dmem_wstrb_in = 4'hF;
        for (int k = 0; k < 2; k++) begin
            sample_check();
            chk("reset_ctl", {bus.imem_req_ready_out, bus.dmem_req_ready_out, bus.mem_en_out,
                              bus.mem_we_out, bus.imem_resp_valid_out, bus.dmem_resp_valid_out}, 0);
            advance();
        end
        rst = 0;
        idle_inputs();

        // Directed table: fetch stream, collision, store then load
        for (int k = 0; k < 13; k++) begin
            bus.imem_req_valid_in = tbl[k].iv; bus.imem_addr_in = tbl[k].ia;
            bus.dmem_req_valid_in = tbl[k].dv; bus.dmem_addr_in = tbl[k].da;
            bus.dmem_we_in = tbl[k].we; bus.dmem_wstrb_in = tbl[k].ws; bus.dmem_wdata_in = tbl[k].wd;
            sample_check();
            chk($sformatf("tbl%0d_ready", k), {bus.imem_req_ready_out, bus.dmem_req_ready_out}, {tbl[k].e_ir, tbl[k].e_dr});
            chk($sformatf("tbl%0d_mem", k), {bus.mem_en_out, bus.mem_we_out, bus.mem_addr_out},
                {tbl[k].e_en, tbl[k].e_we, tbl[k].e_ma});
            chk($sformatf("tbl%0d_resp", k), {bus.imem_resp_valid_out, bus.dmem_resp_valid_out}, {tbl[k].e_irv, tbl[k].e_drv});
            chk($sformatf("tbl%0d_rdata", k), {bus.imem_resp_data_out, bus.dmem_resp_data_out}, {tbl[k].e_ird, tbl[k].e_drd});
            advance();
        end
        idle_inputs();

        // Starvation guard: both sides valid every cycle -> D D D D I repeating
        for (int k = 0; k < 15; k++) begin
            if (k == 0) begin
                bus.imem_req_valid_in = 1; bus.imem_addr_in = 32'h40;
                bus.dmem_req_valid_in = 1; bus.dmem_addr_in = 32'h80; bus.dmem_we_in = 0;
            end
            sample_check();
            chk($sformatf("starve_grant%0d", k), {bus.imem_req_ready_out, bus.dmem_req_ready_out},
                (k % 5 == 4) ? 2'b10 : 2'b01);
            advance();
            if (acc_i) bus.imem_addr_in = bus.imem_addr_in + 32'h4;
            if (acc_d) bus.dmem_addr_in = bus.dmem_addr_in + 32'h4;
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) begin sample_check(); advance(); end

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            if (!bus.imem_req_valid_in && $urandom_range(0, 99) < 60) begin
                bus.imem_req_valid_in = 1;
                bus.imem_addr_in = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            end
            if (!bus.dmem_req_valid_in && $urandom_range(0, 99) < 60) begin
                bus.dmem_req_valid_in = 1;
                bus.dmem_addr_in  = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
                bus.dmem_we_in    = ($urandom_range(0, 2) == 0);
                bus.dmem_wstrb_in = 4'($urandom_range(1, 15));
                bus.dmem_wdata_in = $urandom;
            end
            sample_check();
            advance();
            if (acc_i) bus.imem_req_valid_in = 0;
            if (acc_d) bus.dmem_req_valid_in = 0;
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) begin sample_check(); advance(); end

        // Reset right after an accepted load: its response must be dropped
        bus.dmem_req_valid_in = 1; bus.dmem_addr_in = 32'h40;
        sample_check(); advance();
        rst = 1;
        bus.imem_req_valid_in = 1; bus.imem_addr_in = 32'h14; bus.dmem_addr_in = 32'h44;
        sample_check();
        chk("rst_mid_ctl", {bus.imem_req_ready_out, bus.dmem_req_ready_out, bus.mem_en_out, bus.mem_we_out,
                            bus.imem_resp_valid_out, bus.dmem_resp_valid_out}, 0);
        chk("rst_mid_data", {bus.mem_addr_out | bus.mem_wdata_out[29:0], bus.imem_resp_data_out | bus.dmem_resp_data_out}, 0);
        advance();
        rst = 0;
        idle_inputs();
        sample_check();
        chk("no_resp_after_rst", {bus.imem_resp_valid_out, bus.dmem_resp_valid_out}, 0);
        advance();
        bus.imem_req_valid_in = 1; bus.imem_addr_in = 32'h14;
        sample_check();
        chk("clean_grant", {bus.imem_req_ready_out, bus.dmem_req_ready_out, bus.mem_en_out, bus.mem_addr_out},
            {3'b101, 30'd5});
        advance();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin sample_check(); advance(); end

        // Latency-1 instance: alternating fetch/load, each answered one cycle later
        for (int k = 0; k < 9; k++) begin
            bus2.imem_req_valid_in = (k < 8) && (k % 2 == 0);
            bus2.imem_addr_in      = 32'(k * 4);
            bus2.dmem_req_valid_in = (k < 8) && (k % 2 == 1);
            bus2.dmem_addr_in      = 32'((32 + k) * 4);
            #2;
            if (k < 8) chk($sformatf("l1_ready%0d", k), {bus2.imem_req_ready_out, bus2.dmem_req_ready_out},
                           (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k == 0) begin
                chk("l1_resp0", {bus2.imem_resp_valid_out, bus2.dmem_resp_valid_out}, 2'b00);
            end else if ((k - 1) % 2 == 0) begin
                chk($sformatf("l1_resp%0d", k), {bus2.imem_resp_valid_out, bus2.dmem_resp_valid_out}, 2'b10);
                chk($sformatf("l1_idata%0d", k), bus2.imem_resp_data_out, 32'(32'h1000 + k - 1));
            end else begin
                chk($sformatf("l1_resp%0d", k), {bus2.imem_resp_valid_out, bus2.dmem_resp_valid_out}, 2'b01);
                chk($sformatf("l1_ddata%0d", k), bus2.dmem_resp_data_out, 32'(32'h1000 + 32 + k - 1));
            end
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
